pc_gen: RTL and testbench
=========================

PC_GEN -- requirements
Module: pc_gen

Interface
REQ-001 Parameter XLEN, default 32, SHALL set PC and target width.
REQ-002 Parameter RESET_ADDR, default 32'h0000_0000, SHALL be the PC value loaded at reset.
REQ-003 Parameter INC, default 4, SHALL be the sequential increment in bytes.
REQ-004 clk_i  in  1  SHALL be the single clock; every register SHALL update on its rising edge.
REQ-005 rst_i  in  1  SHALL be the reset: synchronous, active-high.
REQ-006 stall_i  in  1  SHALL mean "do not issue a new fetch request".
REQ-007 branch_i  in  1  SHALL signal a branch/jump redirect.
REQ-008 branch_target_i  in  XLEN  SHALL carry the branch target.
REQ-009 trap_i  in  1  SHALL signal a trap redirect.
REQ-010 trap_vector_i  in  XLEN  SHALL carry the trap target.
REQ-011 pc_o  out  XLEN  SHALL be the fetch address.
REQ-012 pc_valid_o  out  1  SHALL mean "a fetch request is presented on pc_o".
REQ-013 pc_ready_i  in  1  SHALL mean "instruction memory accepts the request".
REQ-014 redirect_pending_o  out  1  SHALL flag a latched redirect not yet applied.
REQ-015 misaligned_o  out  1  SHALL be a one-cycle pulse flagging a misaligned redirect target.

Function
REQ-016 Accept SHALL be defined as pc_valid_o && pc_ready_i in the same cycle.
REQ-017 The FSM SHALL have three states: BOOT, RUN and HOLD.
REQ-018 The FSM SHALL leave BOOT for RUN unconditionally one cycle after rst_i deasserts; pc_valid_o SHALL be 0 in BOOT.
REQ-019 In RUN, pc_valid_o SHALL equal !stall_i.
REQ-020 The FSM SHALL go RUN->HOLD when pc_valid_o=1 and pc_ready_i=0.
REQ-021 In HOLD, pc_valid_o SHALL stay 1 and pc_o SHALL stay stable regardless of stall_i, branch_i and trap_i.
REQ-022 The FSM SHALL go HOLD->RUN on accept.
REQ-023 Next-PC priority SHALL be: trap_vector_i, then branch_target_i, then the latched pending target, then pc_o+INC.
REQ-024 pc_o+INC SHALL wrap modulo 2^XLEN.
REQ-025 On accept in RUN, pc_o SHALL load next-PC on the following edge, giving zero-bubble sequential issue (one request per cycle while pc_ready_i=1).
REQ-026 A redirect in RUN while pc_valid_o=0 (stalled) SHALL load pc_o directly on the next edge; redirect_pending_o SHALL stay 0.
REQ-027 A redirect in HOLD, or in a RUN cycle without accept, SHALL be latched into a pending register and redirect_pending_o SHALL be set.
REQ-028 On the accepting edge, pc_o SHALL load the pending target and pending SHALL clear.
REQ-029 A trap arriving while a branch is pending SHALL overwrite the pending target; a branch arriving while a trap is pending SHALL be ignored.
REQ-030 A redirect in the same cycle as accept SHALL be applied directly (pc_o loads the redirect target) and SHALL NOT set pending.
REQ-031 A redirect target with bits [1:0] != 0 SHALL be loaded with [1:0] forced to 0, and misaligned_o SHALL pulse high on the next cycle.

Reset
REQ-032 While rst_i=1 at an edge, the block SHALL set pc_o=RESET_ADDR, pc_valid_o=0, redirect_pending_o=0, misaligned_o=0, pending register=0 and state=BOOT.
REQ-033 Reset SHALL override every input, including mid-HOLD and pending redirects, with no residue.

Configuration
REQ-034 With PC_COMPRESSED_EN defined, the block SHALL add input inc2_i (1 bit); when inc2_i=1 the increment SHALL be 2 instead of INC, and the misalignment check SHALL use bit [0] only.
REQ-035 Without PC_COMPRESSED_EN, inc2_i SHALL NOT exist, the increment SHALL always be INC, and the check SHALL use bits [1:0].

Structure
REQ-036 Shared package titan_pkg SHALL hold XLEN, the RESET_ADDR default, and the pc_gen state enum (BOOT, RUN, HOLD).
REQ-037 The incrementer SHALL be sub-module pc_add_n: a parametrised XLEN-wide adder with a selectable increment.

Verification
REQ-038 Reset release, ready=1, no stall -> pc_valid_o=0 for one cycle, then pc_o = 0x0, 0x4, 0x8, ... on consecutive cycles.
REQ-039 ready=0 for 3 cycles at pc_o=0x10, branch_i pulsed to target 0x200 in the 2nd cycle -> pc_o holds 0x10 and redirect_pending_o=1 until accept; next pc_o=0x200.
REQ-040 Branch to 0x300 pending, then trap to 0x80 before accept -> after accept pc_o=0x80; a later branch while the trap is pending is ignored.
REQ-041 pc_o=0xFFFF_FFFC, accept with no redirect -> next pc_o=0x0.
REQ-042 Branch target 0x103 -> pc_o=0x100 and misaligned_o=1 for exactly one cycle; with PC_COMPRESSED_EN defined and target 0x102 -> pc_o=0x102 and no pulse.
REQ-043 rst_i asserted while in HOLD with a pending redirect -> next cycle pc_o=RESET_ADDR, pc_valid_o=0 and redirect_pending_o=0.

Source files
------------

// File: rtl/titan_pkg.sv
// Shared definitions for the titan front end: datapath width, reset PC and pc_gen FSM states.
package titan_pkg;

    localparam int XLEN = 32;
    localparam logic [XLEN-1:0] RESET_ADDR_DEFAULT = 32'h0000_0000;

    typedef enum logic [1:0] {
        BOOT = 2'd0,
        RUN  = 2'd1,
        HOLD = 2'd2
    } pc_state_e;

endpackage

// File: rtl/pc_add_n.sv
// XLEN-wide PC incrementer; sel2 swaps the default increment for a 2-byte step.
module pc_add_n #(
    parameter int XLEN = 32,
    parameter int INC  = 4
) (
    input  logic [XLEN-1:0] a,
    input  logic            sel2,
    output logic [XLEN-1:0] sum
);

    localparam logic [XLEN-1:0] INC_W = XLEN'(INC);
    localparam logic [XLEN-1:0] TWO_W = XLEN'(2);

    // Carry out of the top bit is dropped, so the PC wraps modulo 2^XLEN.
    assign sum = a + (sel2 ? TWO_W : INC_W);

endmodule

// File: rtl/pc_gen.sv
// Fetch PC generator with BOOT/RUN/HOLD handshake FSM and pending-redirect latch.
// Optional macro PC_COMPRESSED_EN adds inc2_i (2-byte step) and relaxes alignment to 2 bytes.
module pc_gen #(
    parameter int              XLEN       = titan_pkg::XLEN,
    parameter logic [XLEN-1:0] RESET_ADDR = XLEN'(titan_pkg::RESET_ADDR_DEFAULT),
    parameter int              INC        = 4
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            stall_i,
    input  logic            branch_i,
    input  logic [XLEN-1:0] branch_target_i,
    input  logic            trap_i,
    input  logic [XLEN-1:0] trap_vector_i,
`ifdef PC_COMPRESSED_EN
    input  logic            inc2_i,
`endif
    input  logic            pc_ready_i,
    output logic [XLEN-1:0] pc_o,
    output logic            pc_valid_o,
    output logic            redirect_pending_o,
    output logic            misaligned_o
);

    import titan_pkg::*;

    function automatic logic [XLEN-1:0] align(input logic [XLEN-1:0] t);
`ifdef PC_COMPRESSED_EN
        return {t[XLEN-1:1], 1'b0};
`else
        return {t[XLEN-1:2], 2'b00};
`endif
    endfunction

    pc_state_e       state, state_nxt;
    logic [XLEN-1:0] pc_q;
    logic [XLEN-1:0] pc_inc;
    logic [XLEN-1:0] pend_tgt;
    logic            pend_vld;
    logic            pend_trap;
    logic            misal_q;
    logic            pc_valid;
    logic            accept;
    logic            inc2;
    logic [XLEN-1:0] raw_tgt;
    logic [XLEN-1:0] redir_tgt;
    logic            redir_misal;
    logic            take_redir;

`ifdef PC_COMPRESSED_EN
    assign inc2 = inc2_i;
`else
    assign inc2 = 1'b0;
`endif

    pc_add_n #(
        .XLEN (XLEN),
        .INC  (INC)
    ) u_inc (
        .a    (pc_q),
        .sel2 (inc2),
        .sum  (pc_inc)
    );

    always_comb begin
        pc_valid  = 1'b0;
        state_nxt = state;
        case (state)
            BOOT: state_nxt = RUN;
            RUN: begin
                pc_valid = !stall_i;
                if (!stall_i && !pc_ready_i) state_nxt = HOLD;
            end
            HOLD: begin
                pc_valid = 1'b1;
                if (pc_ready_i) state_nxt = RUN;
            end
            default: state_nxt = BOOT;
        endcase
    end

    assign accept      = pc_valid && pc_ready_i;
    assign raw_tgt     = trap_i ? trap_vector_i : branch_target_i;
    assign redir_tgt   = align(raw_tgt);
    assign redir_misal = (raw_tgt != redir_tgt);
    // A branch cannot displace a pending trap unless it lands on the accepting edge.
    assign take_redir  = (state != BOOT) &&
                         (trap_i || (branch_i && !(pend_vld && pend_trap && !accept)));

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state     <= BOOT;
            pc_q      <= RESET_ADDR;
            pend_vld  <= 1'b0;
            pend_trap <= 1'b0;
            pend_tgt  <= '0;
            misal_q   <= 1'b0;
        end else begin
            state   <= state_nxt;
            misal_q <= take_redir && redir_misal;
            if (accept) begin
                pc_q      <= take_redir ? redir_tgt : (pend_vld ? pend_tgt : pc_inc);
                pend_vld  <= 1'b0;
                pend_trap <= 1'b0;
                pend_tgt  <= '0;
            end else if (take_redir) begin
                if (state == RUN && !pc_valid) begin
                    pc_q <= redir_tgt;
                end else begin
                    pend_vld  <= 1'b1;
                    pend_trap <= trap_i;
                    pend_tgt  <= redir_tgt;
                end
            end
        end
    end

    assign pc_o               = pc_q;
    assign pc_valid_o         = pc_valid;
    assign redirect_pending_o = pend_vld;
    assign misaligned_o       = misal_q;

endmodule

// File: tb/tb_pc_gen.sv
// Self-checking bench for pc_gen: expected fetch addresses are queued as stimulus is driven
// and popped whenever the DUT accepts a request.
module tb_pc_gen;

    logic        clk = 1'b0;
    logic        rst_i = 1'b1;
    logic        stall_i = 1'b0;
    logic        branch_i = 1'b0;
    logic        trap_i = 1'b0;
    logic        pc_ready_i = 1'b1;
    logic [31:0] branch_target_i = '0;
    logic [31:0] trap_vector_i = '0;
`ifdef PC_COMPRESSED_EN
    logic        inc2_i = 1'b0;
    localparam logic [31:0] MIS_TGT = 32'h0000_0102;
    localparam logic [31:0] MIS_EXP = 32'h0000_0102;
    localparam logic        MIS_PULSE = 1'b0;
`else
    localparam logic [31:0] MIS_TGT = 32'h0000_0103;
    localparam logic [31:0] MIS_EXP = 32'h0000_0100;
    localparam logic        MIS_PULSE = 1'b1;
`endif
    logic [31:0] pc_o;
    logic        pc_valid_o;
    logic        redirect_pending_o;
    logic        misaligned_o;

    int          n_checks = 0;
    int          n_fail = 0;
    logic [31:0] exp_q[$];
    logic [31:0] exp_pc;

    pc_gen dut (
        .clk_i              (clk),
        .rst_i              (rst_i),
        .stall_i            (stall_i),
        .branch_i           (branch_i),
        .branch_target_i    (branch_target_i),
        .trap_i             (trap_i),
        .trap_vector_i      (trap_vector_i),
`ifdef PC_COMPRESSED_EN
        .inc2_i             (inc2_i),
`endif
        .pc_ready_i         (pc_ready_i),
        .pc_o               (pc_o),
        .pc_valid_o         (pc_valid_o),
        .redirect_pending_o (redirect_pending_o),
        .misaligned_o       (misaligned_o)
    );

    always #5 clk = ~clk;

    task automatic next_cycle;
        @(posedge clk);
        #1;
    endtask

    task automatic sample;
        @(negedge clk);
    endtask

    task automatic test_reset;
        rst_i = 1'b1;
        pc_ready_i = 1'b1;
        repeat (2) next_cycle;
        sample;
        n_checks++; if (pc_o !== 32'h0) begin n_fail++; $display("FAIL reset_pc: got %h want %h", pc_o, 32'h0); end
        n_checks++; if (pc_valid_o !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b want 0", pc_valid_o); end
        n_checks++; if (redirect_pending_o !== 1'b0) begin n_fail++; $display("FAIL reset_pending: got %b want 0", redirect_pending_o); end
        n_checks++; if (misaligned_o !== 1'b0) begin n_fail++; $display("FAIL reset_misal: got %b want 0", misaligned_o); end
    endtask

    task automatic test_sequential;
        for (int i = 0; i < 4; i++) exp_q.push_back(32'(i * 4));
        next_cycle;
        rst_i = 1'b0;
        sample;
        n_checks++; if (pc_valid_o !== 1'b0) begin n_fail++; $display("FAIL boot_valid: got %b want 0", pc_valid_o); end
        for (int i = 0; i < 4; i++) begin
            next_cycle;
            sample;
            exp_pc = exp_q.pop_front(); n_checks++;
            if (!(pc_valid_o && pc_ready_i) || pc_o !== exp_pc) begin
                n_fail++; $display("FAIL seq_pc[%0d]: got pc=%h valid=%b want pc=%h valid=1", i, pc_o, pc_valid_o, exp_pc);
            end
        end
    endtask

    task automatic test_hold_branch;
        next_cycle; pc_ready_i = 1'b0;
        sample;
        n_checks++; if (pc_o !== 32'h10 || pc_valid_o !== 1'b1) begin n_fail++; $display("FAIL hold_enter: got pc=%h valid=%b want pc=00000010 valid=1", pc_o, pc_valid_o); end
        next_cycle; stall_i = 1'b1; branch_i = 1'b1; branch_target_i = 32'h200;
        sample;
        n_checks++; if (pc_o !== 32'h10 || pc_valid_o !== 1'b1) begin n_fail++; $display("FAIL hold_stable: got pc=%h valid=%b want pc=00000010 valid=1", pc_o, pc_valid_o); end
        next_cycle; stall_i = 1'b0; branch_i = 1'b0;
        sample;
        n_checks++; if (pc_o !== 32'h10 || redirect_pending_o !== 1'b1) begin n_fail++; $display("FAIL hold_pending: got pc=%h pend=%b want pc=00000010 pend=1", pc_o, redirect_pending_o); end
        next_cycle; pc_ready_i = 1'b1; exp_q.push_back(32'h10);
        sample;
        exp_pc = exp_q.pop_front(); n_checks++;
        if (!(pc_valid_o && pc_ready_i) || pc_o !== exp_pc) begin n_fail++; $display("FAIL hold_accept: got pc=%h valid=%b want pc=%h valid=1", pc_o, pc_valid_o, exp_pc); end
        next_cycle; exp_q.push_back(32'h200);
        sample;
        exp_pc = exp_q.pop_front(); n_checks++;
        if (!(pc_valid_o && pc_ready_i) || pc_o !== exp_pc) begin n_fail++; $display("FAIL hold_target: got pc=%h valid=%b want pc=%h valid=1", pc_o, pc_valid_o, exp_pc); end
        n_checks++; if (redirect_pending_o !== 1'b0) begin n_fail++; $display("FAIL hold_clear: got %b want 0", redirect_pending_o); end
    endtask

    task automatic test_trap_override;
        next_cycle; pc_ready_i = 1'b0; branch_i = 1'b1; branch_target_i = 32'h300;
        sample;
        n_checks++; if (pc_o !== 32'h204) begin n_fail++; $display("FAIL trap_start_pc: got %h want 00000204", pc_o); end
        next_cycle; branch_i = 1'b0; trap_i = 1'b1; trap_vector_i = 32'h80;
        sample;
        n_checks++; if (redirect_pending_o !== 1'b1) begin n_fail++; $display("FAIL branch_pending: got %b want 1", redirect_pending_o); end
        next_cycle; trap_i = 1'b0; branch_i = 1'b1; branch_target_i = 32'h400;
        sample;
        next_cycle; branch_i = 1'b0; pc_ready_i = 1'b1; exp_q.push_back(32'h204);
        sample;
        exp_pc = exp_q.pop_front(); n_checks++;
        if (!(pc_valid_o && pc_ready_i) || pc_o !== exp_pc) begin n_fail++; $display("FAIL trap_accept: got pc=%h valid=%b want pc=%h valid=1", pc_o, pc_valid_o, exp_pc); end
        next_cycle; exp_q.push_back(32'h80);
        sample;
        exp_pc = exp_q.pop_front(); n_checks++;
        if (!(pc_valid_o && pc_ready_i) || pc_o !== exp_pc) begin n_fail++; $display("FAIL trap_target: got pc=%h valid=%b want pc=%h valid=1", pc_o, pc_valid_o, exp_pc); end
    endtask

    task automatic test_back_to_back;
        next_cycle; branch_i = 1'b1; branch_target_i = 32'h500; exp_q.push_back(32'h84);
        sample;
        exp_pc = exp_q.pop_front(); n_checks++;
        if (!(pc_valid_o && pc_ready_i) || pc_o !== exp_pc) begin n_fail++; $display("FAIL b2b_accept: got pc=%h valid=%b want pc=%h valid=1", pc_o, pc_valid_o, exp_pc); end
        next_cycle; branch_i = 1'b0; exp_q.push_back(32'h500);
        sample;
        exp_pc = exp_q.pop_front(); n_checks++;
        if (!(pc_valid_o && pc_ready_i) || pc_o !== exp_pc) begin n_fail++; $display("FAIL b2b_target: got pc=%h valid=%b want pc=%h valid=1", pc_o, pc_valid_o, exp_pc); end
        n_checks++; if (redirect_pending_o !== 1'b0) begin n_fail++; $display("FAIL b2b_pending: got %b want 0", redirect_pending_o); end
    endtask

    task automatic test_stall_wrap;
        next_cycle; stall_i = 1'b1; branch_i = 1'b1; branch_target_i = 32'hFFFF_FFFC;
        sample;
        n_checks++; if (pc_valid_o !== 1'b0 || pc_o !== 32'h504) begin n_fail++; $display("FAIL stall_state: got pc=%h valid=%b want pc=00000504 valid=0", pc_o, pc_valid_o); end
        next_cycle; stall_i = 1'b0; branch_i = 1'b0; exp_q.push_back(32'hFFFF_FFFC);
        sample;
        exp_pc = exp_q.pop_front(); n_checks++;
        if (!(pc_valid_o && pc_ready_i) || pc_o !== exp_pc) begin n_fail++; $display("FAIL stall_direct: got pc=%h valid=%b want pc=%h valid=1", pc_o, pc_valid_o, exp_pc); end
        n_checks++; if (redirect_pending_o !== 1'b0) begin n_fail++; $display("FAIL stall_pending: got %b want 0", redirect_pending_o); end
        next_cycle; exp_q.push_back(32'h0);
        sample;
        exp_pc = exp_q.pop_front(); n_checks++;
        if (!(pc_valid_o && pc_ready_i) || pc_o !== exp_pc) begin n_fail++; $display("FAIL wrap_pc: got pc=%h valid=%b want pc=%h valid=1", pc_o, pc_valid_o, exp_pc); end
    endtask

    task automatic test_misaligned;
        next_cycle; branch_i = 1'b1; branch_target_i = MIS_TGT; exp_q.push_back(32'h4);
        sample;
        exp_pc = exp_q.pop_front(); n_checks++;
        if (!(pc_valid_o && pc_ready_i) || pc_o !== exp_pc) begin n_fail++; $display("FAIL mis_accept: got pc=%h valid=%b want pc=%h valid=1", pc_o, pc_valid_o, exp_pc); end
        n_checks++; if (misaligned_o !== 1'b0) begin n_fail++; $display("FAIL mis_early: got %b want 0", misaligned_o); end
        next_cycle; branch_i = 1'b0; exp_q.push_back(MIS_EXP);
        sample;
        exp_pc = exp_q.pop_front(); n_checks++;
        if (!(pc_valid_o && pc_ready_i) || pc_o !== exp_pc) begin n_fail++; $display("FAIL mis_target: got pc=%h valid=%b want pc=%h valid=1", pc_o, pc_valid_o, exp_pc); end
        n_checks++; if (misaligned_o !== MIS_PULSE) begin n_fail++; $display("FAIL mis_pulse: got %b want %b", misaligned_o, MIS_PULSE); end
        next_cycle; exp_q.push_back(MIS_EXP + 32'h4);
        sample;
        exp_pc = exp_q.pop_front(); n_checks++;
        if (!(pc_valid_o && pc_ready_i) || pc_o !== exp_pc) begin n_fail++; $display("FAIL mis_next: got pc=%h valid=%b want pc=%h valid=1", pc_o, pc_valid_o, exp_pc); end
        n_checks++; if (misaligned_o !== 1'b0) begin n_fail++; $display("FAIL mis_width: got %b want 0", misaligned_o); end
    endtask

    task automatic test_reset_in_hold;
        next_cycle; pc_ready_i = 1'b0; branch_i = 1'b1; branch_target_i = 32'h700;
        sample;
        n_checks++; if (pc_o !== MIS_EXP + 32'h8 || pc_valid_o !== 1'b1) begin n_fail++; $display("FAIL rh_start: got pc=%h valid=%b want pc=%h valid=1", pc_o, pc_valid_o, MIS_EXP + 32'h8); end
        next_cycle; branch_i = 1'b0; rst_i = 1'b1;
        sample;
        n_checks++; if (redirect_pending_o !== 1'b1) begin n_fail++; $display("FAIL rh_pending: got %b want 1", redirect_pending_o); end
        next_cycle;
        sample;
        n_checks++; if (pc_o !== 32'h0 || pc_valid_o !== 1'b0 || redirect_pending_o !== 1'b0 || misaligned_o !== 1'b0) begin
            n_fail++; $display("FAIL rh_reset: got pc=%h valid=%b pend=%b mis=%b want pc=00000000 valid=0 pend=0 mis=0", pc_o, pc_valid_o, redirect_pending_o, misaligned_o);
        end
        next_cycle; rst_i = 1'b0; pc_ready_i = 1'b1; exp_q.push_back(32'h0);
        sample;
        n_checks++; if (pc_valid_o !== 1'b0) begin n_fail++; $display("FAIL rh_boot: got %b want 0", pc_valid_o); end
        next_cycle;
        sample;
        exp_pc = exp_q.pop_front(); n_checks++;
        if (!(pc_valid_o && pc_ready_i) || pc_o !== exp_pc) begin n_fail++; $display("FAIL rh_restart: got pc=%h valid=%b want pc=%h valid=1", pc_o, pc_valid_o, exp_pc); end
    endtask

    initial begin
        test_reset;
        test_sequential;
        test_hold_branch;
        test_trap_override;
        test_back_to_back;
        test_stall_wrap;
        test_misaligned;
        test_reset_in_hold;
        n_checks++; if (exp_q.size() != 0) begin n_fail++; $display("FAIL scoreboard_drain: got %0d left want 0", exp_q.size()); end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
